day_counter: RTL and testbench
==============================

Name: day_counter

Overview:
- Day-of-month counter in the calendar chain, between the hour counter and the month counter.
- Counts 1..N, where N is the number of days in the current month, taken from the month and year values fed back from the downstream counters.
- Emits a one-cycle carry pulse to the month counter when it wraps from N to 1.
- Supports manual adjust through the shared select_item/up/down bus.

Parameters:
- SELECT_DAY, 3'b011, select_item code that puts this block in adjust mode.
- YEAR_W, 14, width of the year_bin feedback input (years 0..9999).

Ports:
- clk_1Hz  input  1  system tick clock.
- rst_n  input  1  asynchronous active-low reset.
- en_1  input  1  counting enable (run mode).
- up  input  1  adjust increment request, level-sampled each clock.
- down  input  1  adjust decrement request, level-sampled each clock.
- select_item  input  3  adjust-target selector.
- carry_in  input  1  day-advance pulse from the hour counter (23->0 wrap).
- month_bin  input  4  current month (1..12), fed back from the month counter.
- year_bin  input  YEAR_W  current year (binary), fed back from the year counter.
- day_bin  output  5  current day, 1..31.
- carry_out  output  1  one-cycle pulse to the month counter on month rollover.

Behaviour:
- Reset is asynchronous, active-low, clock clk_1Hz. On reset: day_bin=5'd1, carry_out=0.
- dim (days in month) is combinational from month_bin/year_bin:
  - months 1,3,5,7,8,10,12 -> 31; months 4,6,9,11 -> 30; month 2 -> 28, or 29 in a leap year (see Optional Feature).
  - Illegal month (0, 13..15) -> 31.
- Priority per rising edge, highest first:
  1. Adjust: select_item==SELECT_DAY.
     - up: day_bin==dim -> 1, else +1.
     - else down: day_bin==1 -> dim, else -1.
     - up and down both high -> up wins.
     - If day_bin>dim on entry, up gives 1 and down gives dim.
     - carry_out<=0 always in adjust mode; manual adjust never carries.
  2. Count: en_1 && carry_in.
     - day_bin>=dim -> day_bin<=1, carry_out<=1.
     - Else day_bin+1, carry_out<=0.
  3. Clamp: day_bin>dim (month or year changed under it) -> day_bin<=dim, carry_out<=0.
  4. Otherwise hold day_bin, carry_out<=0.
- carry_out is registered and high for exactly one clock after the wrap edge; the month counter consumes it on the next edge (1-cycle latency).
- Clamp settles within one clock of the month_bin/year_bin change.
- carry_in while in adjust mode is dropped.
- day_bin never leaves 1..31 and never reads 0.

Optional Feature:
- Macro: DAY_LEAP_YEAR_EN.
- Defined: February has 29 days when year_bin%4==0 && (year_bin%100!=0 || year_bin%400==0); otherwise 28.
- Not defined: February is always 28 days; year_bin is unused (port kept for a stable interface).

Decomposition:
- Shared package calendar_pkg holds:
  - SELECT_* item codes: SEC, MIN, HOUR, DAY, MONTH, YEAR.
  - Month constants FEB=2 and related.
  - Widths DAY_W=5, MONTH_W=4, YEAR_W=14.
- Sub-module days_in_month (combinational: month_bin, year_bin -> dim[4:0], contains the leap logic). It is reused later by the date-set validator.
- day_counter holds the registers and priority logic only.

Test Plan:
- Reset mid-count with day_bin=17 -> day_bin=1, carry_out=0 immediately, asynchronously.
- month=4, day=30, en_1=1, carry_in=1 -> next edge day=1, carry_out=1 for one clock; following edge carry_out=0.
- Leap year, macro defined: year=2024, month=2, day=28, count -> 29, no carry; count again -> 1 with carry. With year=1900 or 2023: 28 -> 1 with carry. With year=2000: 29 is reached.
- Adjust: select_item=3'b011, month=2, year=2023, day=1, down -> 28; up from 28 -> 1; up and down together from 5 -> 6; carry_in pulses during adjust change nothing, carry_out stays 0.
- Clamp: day=31, month_bin switches 1->2 (year 2023), idle -> next edge day=28, carry_out=0.
- Without DAY_LEAP_YEAR_EN: year=2024, month=2, day=28, count -> 1 with carry.

Source files
------------

// File: rtl/calendar_pkg.sv
// calendar_pkg: constants shared by the calendar counter chain.
//   - SELECT_* : adjust-target codes driven on the shared select_item bus.
//   - Month numbers used by the days-in-month logic.
//   - Field widths for the day, month and year registers.
package calendar_pkg;

  localparam logic [2:0] SELECT_SEC   = 3'b000;
  localparam logic [2:0] SELECT_MIN   = 3'b001;
  localparam logic [2:0] SELECT_HOUR  = 3'b010;
  localparam logic [2:0] SELECT_DAY   = 3'b011;
  localparam logic [2:0] SELECT_MONTH = 3'b100;
  localparam logic [2:0] SELECT_YEAR  = 3'b101;

  localparam int DAY_W   = 5;
  localparam int MONTH_W = 4;
  localparam int YEAR_W  = 14;

  localparam logic [MONTH_W-1:0] JAN = 4'd1;
  localparam logic [MONTH_W-1:0] FEB = 4'd2;
  localparam logic [MONTH_W-1:0] APR = 4'd4;
  localparam logic [MONTH_W-1:0] JUN = 4'd6;
  localparam logic [MONTH_W-1:0] SEP = 4'd9;
  localparam logic [MONTH_W-1:0] NOV = 4'd11;
  localparam logic [MONTH_W-1:0] DEC = 4'd12;

  localparam logic [DAY_W-1:0] DAYS_LONG  = 5'd31;
  localparam logic [DAY_W-1:0] DAYS_SHORT = 5'd30;
  localparam logic [DAY_W-1:0] DAYS_FEB   = 5'd28;
  localparam logic [DAY_W-1:0] DAYS_LEAP  = 5'd29;

endpackage

// File: rtl/days_in_month.sv
// days_in_month: combinational number of days in a month.
// Ports:
//   month_bin [3:0]        month 1..12 (illegal values give 31)
//   year_bin  [YEAR_W-1:0] binary year, only used for leap years
//   dim       [4:0]        days in the given month
// Build option: DAY_LEAP_YEAR_EN enables the Gregorian leap-year rule;
// without it February is always 28 days and year_bin is ignored.
module days_in_month #(
  parameter int YEAR_W = calendar_pkg::YEAR_W
) (
  input  logic [3:0]        month_bin,
  input  logic [YEAR_W-1:0] year_bin,
  output logic [4:0]        dim
);
  import calendar_pkg::*;

  logic leap;

`ifdef DAY_LEAP_YEAR_EN
  // Divisible by 4, except centuries unless divisible by 400.
  assign leap = ((year_bin % YEAR_W'(4)) == '0) &&
                (((year_bin % YEAR_W'(100)) != '0) ||
                 ((year_bin % YEAR_W'(400)) == '0));
`else
  // year_bin is kept on the interface; fold it away here.
  logic unused_year;
  assign unused_year = ^year_bin;
  assign leap        = 1'b0;
`endif

  always_comb begin
    dim = DAYS_LONG;
    case (month_bin)
      FEB:                dim = leap ? DAYS_LEAP : DAYS_FEB;
      APR, JUN, SEP, NOV: dim = DAYS_SHORT;
      default:            dim = DAYS_LONG;
    endcase
  end

endmodule

// File: rtl/day_counter.sv
// day_counter: day-of-month register in the calendar chain.
// Counts 1..dim, where dim comes from the month/year fed back by the
// downstream counters, and pulses carry_out for one clock on wrap.
// Ports:
//   clk_1Hz       system tick clock
//   rst_n         asynchronous active-low reset
//   en_1          run-mode enable
//   up, down      adjust requests (level-sampled, up wins)
//   select_item   adjust target; SELECT_DAY puts this block in adjust mode
//   carry_in      day-advance pulse from the hour counter
//   month_bin     current month (feedback)
//   year_bin      current year (feedback)
//   day_bin       current day 1..31
//   carry_out     registered one-clock pulse to the month counter
// Build option: DAY_LEAP_YEAR_EN (leap-year February, in days_in_month).
module day_counter #(
  parameter logic [2:0] SELECT_DAY = calendar_pkg::SELECT_DAY,
  parameter int         YEAR_W     = calendar_pkg::YEAR_W
) (
  input  logic              clk_1Hz,
  input  logic              rst_n,
  input  logic              en_1,
  input  logic              up,
  input  logic              down,
  input  logic [2:0]        select_item,
  input  logic              carry_in,
  input  logic [3:0]        month_bin,
  input  logic [YEAR_W-1:0] year_bin,
  output logic [4:0]        day_bin,
  output logic              carry_out
);
  import calendar_pkg::*;

  logic [4:0] dim;

  days_in_month #(.YEAR_W(YEAR_W)) u_dim (
    .month_bin (month_bin),
    .year_bin  (year_bin),
    .dim       (dim)
  );

  always_ff @(posedge clk_1Hz or negedge rst_n) begin
    if (!rst_n) begin
      day_bin   <= 5'd1;
      carry_out <= 1'b0;
    end else begin
      carry_out <= 1'b0;
      if (select_item == SELECT_DAY) begin
        // Manual adjust wraps inside the current month and never carries;
        // a stale day above dim snaps to the nearest legal end.
        if (up) begin
          day_bin <= (day_bin >= dim) ? 5'd1 : day_bin + 5'd1;
        end else if (down) begin
          day_bin <= ((day_bin == 5'd1) || (day_bin > dim)) ? dim : day_bin - 5'd1;
        end
      end else if (en_1 && carry_in) begin
        if (day_bin >= dim) begin
          day_bin   <= 5'd1;
          carry_out <= 1'b1;
        end else begin
          day_bin <= day_bin + 5'd1;
        end
      end else if (day_bin > dim) begin
        // Month or year changed underneath us (e.g. Jan 31 -> Feb).
        day_bin <= dim;
      end
    end
  end

endmodule

// File: tb/tb_day_counter.sv
module tb_day_counter;

  logic        clk_1Hz = 1'b0;
  logic        rst_n;
  logic        en_1;
  logic        up;
  logic        down;
  logic [2:0]  select_item;
  logic        carry_in;
  logic [3:0]  month_bin;
  logic [13:0] year_bin;
  logic [4:0]  day_bin;
  logic        carry_out;

  int total = 0;
  int bad   = 0;
  int m_day;
  int m_carry;
  int nstep = 0;

  day_counter dut (
    .clk_1Hz     (clk_1Hz),
    .rst_n       (rst_n),
    .en_1        (en_1),
    .up          (up),
    .down        (down),
    .select_item (select_item),
    .carry_in    (carry_in),
    .month_bin   (month_bin),
    .year_bin    (year_bin),
    .day_bin     (day_bin),
    .carry_out   (carry_out)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  // Calendar rule straight from the month table.
  function automatic int ref_dim(input int m, input int y);
    bit leap;
    leap = 1'b0;
`ifdef DAY_LEAP_YEAR_EN
    leap = (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
`endif
    if (m == 2) return leap ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock: drive controls, advance the model, compare after the edge.
  task automatic step(input string tag, input logic [2:0] sel, input bit u,
                      input bit d, input bit e, input bit c);
    int dim;
    select_item = sel; up = u; down = d; en_1 = e; carry_in = c;
    dim = ref_dim(int'(month_bin), int'(year_bin));
    @(posedge clk_1Hz);
    m_carry = 0;
    if (sel == 3'b011) begin
      if (u)      m_day = (m_day > dim) ? 1   : (m_day % dim) + 1;
      else if (d) m_day = (m_day > dim) ? dim : ((m_day + dim - 2) % dim) + 1;
    end else if (e && c) begin
      if (m_day >= dim) begin m_day = 1; m_carry = 1; end
      else m_day = m_day + 1;
    end else if (m_day > dim) begin
      m_day = dim;
    end
    #1;
    nstep++;
    $display("step %0d %s sel=%0d u=%0d d=%0d en=%0d ci=%0d mon=%0d yr=%0d -> day=%0d co=%0d",
             nstep, tag, sel, u, d, e, c, month_bin, year_bin, day_bin, carry_out);
    check({tag, ".day"}, 32'(day_bin), m_day);
    check({tag, ".carry"}, 32'(carry_out), m_carry);
  endtask

  initial begin
    rst_n = 1'b0; en_1 = 0; up = 0; down = 0; select_item = 3'd0; carry_in = 0;
    month_bin = 4'd1; year_bin = 14'd2023;
    m_day = 1; m_carry = 0;
    #12;
    check("reset.day", 32'(day_bin), 1);
    check("reset.carry", 32'(carry_out), 0);
    rst_n = 1'b1;

    // Count up to 17, then reset asynchronously between edges.
    for (int i = 0; i < 16; i++) step("count", 3'd0, 0, 0, 1, 1);
    check("count.day17", 32'(day_bin), 17);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.day", 32'(day_bin), 1);
    check("async_rst.carry", 32'(carry_out), 0);
    rst_n = 1'b1;
    m_day = 1; m_carry = 0;

    // April: 30 wraps to 1 with a single-clock carry.
    month_bin = 4'd4;
    step("adj_to30", 3'b011, 0, 1, 0, 0);
    check("apr.day30", 32'(day_bin), 30);
    step("apr_wrap", 3'd0, 0, 0, 1, 1);
    check("apr.wrap_carry", 32'(carry_out), 1);
    step("apr_idle", 3'd0, 0, 0, 1, 0);
    check("apr.carry_drop", 32'(carry_out), 0);

    // Adjust in February 2023.
    month_bin = 4'd2; year_bin = 14'd2023;
    step("adj_down_1", 3'b011, 0, 1, 0, 0);
    check("feb.down_to_28", 32'(day_bin), 28);
    step("adj_up_28", 3'b011, 1, 0, 0, 0);
    check("feb.up_to_1", 32'(day_bin), 1);
    for (int i = 0; i < 4; i++) step("adj_up", 3'b011, 1, 0, 0, 0);
    step("adj_both", 3'b011, 1, 1, 0, 0);
    check("adj.both_up_wins", 32'(day_bin), 6);
    step("adj_carry_in", 3'b011, 0, 0, 1, 1);
    step("adj_carry_in", 3'b011, 0, 0, 1, 1);

    // Clamp: January 31, then month switches to February.
    month_bin = 4'd1;
    for (int i = 0; i < 6; i++) step("adj_down", 3'b011, 0, 1, 0, 0);
    check("jan.day31", 32'(day_bin), 31);
    month_bin = 4'd2;
    step("clamp", 3'd0, 0, 0, 0, 0);
    check("clamp.day28", 32'(day_bin), 28);

    // February across leap/non-leap years (model follows the build option).
    year_bin = 14'd2024;
    step("feb2024", 3'd0, 0, 0, 1, 1);
    step("feb2024", 3'd0, 0, 0, 1, 1);
    year_bin = 14'd1900;
    step("adj1900", 3'b011, 0, 1, 0, 0);
    step("feb1900", 3'd0, 0, 0, 1, 1);
    year_bin = 14'd2000;
    step("adj2000", 3'b011, 0, 1, 0, 0);
    step("feb2000", 3'd0, 0, 0, 1, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [2:0] sel;
      if ($urandom_range(0, 7) == 0) month_bin = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 4))
          0: year_bin = 14'd1900;
          1: year_bin = 14'd2000;
          2: year_bin = 14'd2023;
          3: year_bin = 14'd2024;
          default: year_bin = 14'($urandom_range(0, 9999));
        endcase
      end
      sel = ($urandom_range(0, 3) == 0) ? 3'b011 : 3'($urandom_range(0, 7));
      step("rand", sel, 1'($urandom), 1'($urandom),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1));
      assert (day_bin >= 5'd1) else begin
        bad++;
        $error("FAIL rand.range: observed=%0d expected>=1", day_bin);
      end
      total++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
